cvp14_mem_ctrl: RTL and testbench

Memory port controller for the CVP14 vector processor: owns the single 16-bit external memory port (Addr/RD/WR/DataOut/DataIn) and shares it between the instruction-fetch unit and the vector load/store unit. Fetches move one word. Vector loads and stores move one full 256-bit vector register as 16 consecutive words. The block sits between the core's fetch/decode logic, the vector register file, and the memory pins.

---
 rtl/cvp14_pkg.sv | 43 ++++
 rtl/cvp14_lane_buf.sv | 42 ++++
 rtl/cvp14_mem_ctrl.sv | 175 +++++++++++++++++
 tb/tb_cvp14_mem_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_pkg.sv
// CVP14 shared definitions: ISA opcodes, vector geometry and the memory
// controller state encoding.
package cvp14_pkg;

    localparam int LANES      = 16;
    localparam int WORD       = 16;
    localparam int VEC_W      = LANES * WORD;
    localparam int LANE_IDX_W = $clog2(LANES);

    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

    typedef enum logic [3:0] {
        OP_VADD = 4'h0,
        OP_VDOT = 4'h1,
        OP_SMUL = 4'h2,
        OP_SST  = 4'h3,
        OP_VLD  = 4'h4,
        OP_VST  = 4'h5,
        OP_SLL  = 4'h6,
        OP_SADD = 4'h7,
        OP_SSUB = 4'h8,
        OP_SAND = 4'h9,
        OP_SOR  = 4'hA,
        OP_SLD  = 4'hB,
        OP_J    = 4'hC,
        OP_BNE  = 4'hD,
        OP_BEZ  = 4'hE,
        OP_NOP  = 4'hF
    } cvp14_op_t;

    typedef enum logic [2:0] {
        IDLE,
        IF_RD,
        IF_WAIT,
        VLD,
        VLD_DRAIN,
        VST,
        DONE
    } mc_state_t;

endpackage

// File: rtl/cvp14_lane_buf.sv
// Vector staging register: assembles load data one lane at a time and
// serves store data one lane at a time.
module cvp14_lane_buf
    import cvp14_pkg::*;
(
    input  logic             Clk1,
    input  logic             Reset,
    input  logic             load_all,
    input  logic [VEC_W-1:0] load_data,
    input  logic             wr_en,
    input  lane_idx_t        wr_idx,
    input  logic [WORD-1:0]  wr_data,
    input  lane_idx_t        rd_idx,
    output logic [WORD-1:0]  rd_data,
    output logic [VEC_W-1:0] vec
);

    logic [VEC_W-1:0] vec_d;
    logic [VEC_W-1:0] vec_q;

    always_comb begin
        vec_d = vec_q;
        if (load_all) begin
            vec_d = load_data;
        end else if (wr_en) begin
            vec_d[WORD*int'(wr_idx) +: WORD] = wr_data;
        end
    end

    // Cleared on reset so an interrupted load never leaks partial data.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    assign rd_data = vec_q[WORD*int'(rd_idx) +: WORD];
    assign vec     = vec_q;

endmodule

// File: rtl/cvp14_mem_ctrl.sv
// CVP14 memory port controller: arbitrates the single external word port
// between instruction fetch and 16-word vector load/store bursts.
module cvp14_mem_ctrl
    import cvp14_pkg::*;
(
    input  logic             Clk1,
    input  logic             Reset,
    input  logic             if_req,
    input  logic [WORD-1:0]  if_addr,
    output logic             if_ack,
    output logic [WORD-1:0]  if_data,
    input  logic             v_req,
    input  logic             v_we,
    input  logic [WORD-1:0]  v_base,
    input  logic [VEC_W-1:0] v_wdata,
    output logic             v_done,
    output logic [VEC_W-1:0] v_rdata,
    output logic             busy,
    output logic [WORD-1:0]  Addr,
    output logic             RD,
    output logic             WR,
    output logic [WORD-1:0]  DataOut,
    input  logic [WORD-1:0]  DataIn
);

    mc_state_t       state_d,   state_q;
    lane_idx_t       cnt_d,     cnt_q;
    logic [WORD-1:0] addr_d,    addr_q;
    logic            rd_d,      rd_q;
    logic            wr_d,      wr_q;
    logic [WORD-1:0] dout_d,    dout_q;
    logic            if_ack_d,  if_ack_q;
    logic [WORD-1:0] if_data_d, if_data_q;
    logic            v_done_d,  v_done_q;
    logic            busy_d,    busy_q;

    logic            buf_load;
    logic            buf_wr_en;
    lane_idx_t       buf_wr_idx;
    lane_idx_t       buf_rd_idx;
    logic [WORD-1:0] buf_rd_data;

    cvp14_lane_buf u_lane_buf (
        .Clk1      (Clk1),
        .Reset     (Reset),
        .load_all  (buf_load),
        .load_data (v_wdata),
        .wr_en     (buf_wr_en),
        .wr_idx    (buf_wr_idx),
        .wr_data   (DataIn),
        .rd_idx    (buf_rd_idx),
        .rd_data   (buf_rd_data),
        .vec       (v_rdata)
    );

    // Stores present the next lane one cycle ahead of the registered DataOut.
    assign buf_rd_idx = cnt_q + lane_idx_t'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        dout_d     = dout_q;
        if_ack_d   = 1'b0;
        if_data_d  = if_data_q;
        v_done_d   = 1'b0;
        buf_load   = 1'b0;
        buf_wr_en  = 1'b0;
        buf_wr_idx = cnt_q - lane_idx_t'(1);

        case (state_q)
            IDLE: begin
                if (v_req) begin
                    cnt_d  = '0;
                    addr_d = v_base;
                    if (v_we) begin
                        state_d  = VST;
                        wr_d     = 1'b1;
                        dout_d   = v_wdata[WORD-1:0];
                        buf_load = 1'b1;
                    end else begin
                        state_d = VLD;
                        rd_d    = 1'b1;
                    end
                end else if (if_req) begin
                    state_d = IF_RD;
                    addr_d  = if_addr;
                    rd_d    = 1'b1;
                end
            end
            IF_RD: begin
                state_d = IF_WAIT;
            end
            IF_WAIT: begin
                if_data_d = DataIn;
                if_ack_d  = 1'b1;
                state_d   = DONE;
            end
            // DataIn in VLD cycle i answers the read issued in cycle i-1.
            VLD: begin
                buf_wr_en = (cnt_q != '0);
                if (cnt_q == LAST_LANE) begin
                    state_d = VLD_DRAIN;
                end else begin
                    rd_d   = 1'b1;
                    addr_d = addr_q + WORD'(1);
                    cnt_d  = cnt_q + lane_idx_t'(1);
                end
            end
            VLD_DRAIN: begin
                buf_wr_en  = 1'b1;
                buf_wr_idx = LAST_LANE;
                v_done_d   = 1'b1;
                state_d    = DONE;
            end
            VST: begin
                if (cnt_q == LAST_LANE) begin
                    v_done_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    wr_d   = 1'b1;
                    addr_d = addr_q + WORD'(1);
                    cnt_d  = cnt_q + lane_idx_t'(1);
                    dout_d = buf_rd_data;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            dout_q    <= '0;
            if_ack_q  <= 1'b0;
            if_data_q <= '0;
            v_done_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            dout_q    <= dout_d;
            if_ack_q  <= if_ack_d;
            if_data_q <= if_data_d;
            v_done_q  <= v_done_d;
            busy_q    <= busy_d;
        end
    end

    assign Addr    = addr_q;
    assign RD      = rd_q;
    assign WR      = wr_q;
    assign DataOut = dout_q;
    assign if_ack  = if_ack_q;
    assign if_data = if_data_q;
    assign v_done  = v_done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cvp14_mem_ctrl.sv
// Bench for cvp14_mem_ctrl: directed and random fetch/load/store traffic
// against a word-array memory and a reference memory image.
module tb_cvp14_mem_ctrl;

    logic         Clk1;
    logic         Reset;
    logic         if_req;
    logic [15:0]  if_addr;
    logic         if_ack;
    logic [15:0]  if_data;
    logic         v_req;
    logic         v_we;
    logic [15:0]  v_base;
    logic [255:0] v_wdata;
    logic         v_done;
    logic [255:0] v_rdata;
    logic         busy;
    logic [15:0]  Addr;
    logic         RD;
    logic         WR;
    logic [15:0]  DataOut;
    logic [15:0]  DataIn;

    logic [15:0]  mem     [0:65535];
    logic [15:0]  ref_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    cvp14_mem_ctrl dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .if_req  (if_req),
        .if_addr (if_addr),
        .if_ack  (if_ack),
        .if_data (if_data),
        .v_req   (v_req),
        .v_we    (v_we),
        .v_base  (v_base),
        .v_wdata (v_wdata),
        .v_done  (v_done),
        .v_rdata (v_rdata),
        .busy    (busy),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .DataOut (DataOut),
        .DataIn  (DataIn)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    function automatic logic [15:0] init_word(input int a);
        if (a == 0) return 16'h7123;
        if (a >= 32'h100 && a <= 32'h10F) return 16'(32'hA000 + (a - 32'h100));
        return 16'((a * 32'h9E37) ^ 32'h5A5A);
    endfunction

    // External memory: a read strobed in one cycle answers in the next; junk otherwise.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
        DataIn = 16'h0;
        forever begin
            @(posedge Clk1);
            if (WR) mem[Addr] = DataOut;
            if (RD) DataIn <= mem[Addr];
            else    DataIn <= 16'($urandom);
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One transaction from request in an IDLE cycle to the IDLE cycle after completion.
    task automatic run_txn(input bit is_vec, input bit we, input logic [15:0] a,
                           input logic [255:0] wd);
        int           exp_lat;
        int           n_act;
        int           done_k;
        int           strobe_err;
        int           addr_err;
        int           dout_err;
        int           busy_low;
        int           stray;
        bit           act;
        bit           exp_rdb;
        bit           exp_wrb;
        logic [255:0] exp_vec;
        logic [255:0] got_vec;
        logic [15:0]  got_if;

        exp_lat = !is_vec ? 3 : (we ? 17 : 18);
        n_act   = is_vec ? 16 : 1;
        for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = ref_mem[16'(a + 16'(i))];
        done_k = 0; strobe_err = 0; addr_err = 0; dout_err = 0; busy_low = 0; stray = 0;
        got_vec = '0; got_if = '0;

        if (is_vec) begin
            v_req = 1'b1; v_we = we; v_base = a; v_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end

        for (int k = 1; k <= 40 && done_k == 0; k++) begin
            @(negedge Clk1);
            act     = (k <= n_act);
            exp_rdb = act && !(is_vec && we);
            exp_wrb = act && is_vec && we;
            if (RD !== exp_rdb) strobe_err++;
            if (WR !== exp_wrb) strobe_err++;
            if (act && Addr !== 16'(a + 16'(k - 1))) addr_err++;
            if (exp_wrb && DataOut !== wd[16*(k-1) +: 16]) dout_err++;
            if (busy !== 1'b1) busy_low++;
            if (is_vec ? (if_ack !== 1'b0) : (v_done !== 1'b0)) stray++;
            if (is_vec ? (v_done === 1'b1) : (if_ack === 1'b1)) begin
                done_k  = k;
                got_vec = v_rdata;
                got_if  = if_data;
                if (is_vec) v_req = 1'b0;
                else        if_req = 1'b0;
            end
            if (k == 1) begin
                // Inputs move after the grant; the transfer must not follow them.
                if (is_vec) begin
                    v_base  = 16'($urandom);
                    v_we    = ~we;
                    v_wdata = {8{$urandom}};
                end else begin
                    if_addr = 16'($urandom);
                end
            end
        end
        if (done_k == 0) begin
            if (is_vec) v_req = 1'b0;
            else        if_req = 1'b0;
        end

        chk(is_vec ? (we ? "vst_latency" : "vld_latency") : "if_latency", done_k, exp_lat);
        chk("strobe_pattern", strobe_err, 0);
        chk("addr_sequence", addr_err, 0);
        chk("stray_pulse", stray, 0);
        chk("busy_during_txn", busy_low, 0);
        if (!is_vec) begin
            chk("if_data", got_if, ref_mem[a]);
        end else if (!we) begin
            chk("v_rdata", got_vec, exp_vec);
        end else begin
            chk("vst_dataout", dout_err, 0);
            for (int i = 0; i < 16; i++) ref_mem[16'(a + 16'(i))] = wd[16*i +: 16];
            for (int i = 0; i < 16; i++) got_vec[16*i +: 16] = mem[16'(a + 16'(i))];
            chk("vst_mem_image", got_vec, wd);
        end

        @(negedge Clk1);
        chk("busy_idle", busy, 0);
    endtask

    logic [255:0] wd_v;
    logic [15:0]  ra;
    int           kind;
    int           late_done;

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);
        Reset = 1'b1; if_req = 1'b0; if_addr = '0; v_req = 1'b0; v_we = 1'b0;
        v_base = '0; v_wdata = '0;
        repeat (3) @(negedge Clk1);
        chk("rst_addr", Addr, 0);
        chk("rst_rd_wr", {RD, WR}, 0);
        chk("rst_dataout", DataOut, 0);
        chk("rst_acks", {if_ack, v_done, busy}, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_v_rdata", v_rdata, 0);
        Reset = 1'b0;
        @(negedge Clk1);

        run_txn(1'b0, 1'b0, 16'h0000, '0);
        run_txn(1'b1, 1'b0, 16'h0100, '0);
        for (int i = 0; i < 16; i++) wd_v[16*i +: 16] = 16'(32'h5500 + i);
        run_txn(1'b1, 1'b1, 16'h0200, wd_v);
        run_txn(1'b1, 1'b0, 16'h0200, '0);
        run_txn(1'b1, 1'b0, 16'hFFF8, '0);

        // Contention: fetch held while the vector is served first.
        if_req = 1'b1; if_addr = 16'h0105;
        run_txn(1'b1, 1'b0, 16'h0300, '0);
        run_txn(1'b0, 1'b0, 16'h0105, '0);

        // Reset while lane 7 of a load is being read.
        v_req = 1'b1; v_we = 1'b0; v_base = 16'h0400;
        repeat (8) @(negedge Clk1);
        chk("lane7_rd", RD, 1);
        chk("lane7_addr", Addr, 16'h0407);
        Reset = 1'b1; v_req = 1'b0;
        @(negedge Clk1);
        chk("midrst_bus", {Addr, RD, WR, DataOut}, 0);
        chk("midrst_ctrl", {if_ack, v_done, busy, if_data}, 0);
        chk("midrst_v_rdata", v_rdata, 0);
        Reset = 1'b0;
        late_done = 0;
        repeat (20) begin
            @(negedge Clk1);
            if (v_done !== 1'b0 || busy !== 1'b0) late_done++;
        end
        chk("midrst_no_done", late_done, 0);
        run_txn(1'b0, 1'b0, 16'h010A, '0);

        for (int t = 0; t < 24; t++) begin
            kind = int'($urandom_range(0, 2));
            ra   = 16'($urandom);
            for (int i = 0; i < 16; i++) wd_v[16*i +: 16] = 16'($urandom);
            run_txn(kind != 0, kind == 2, ra, wd_v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
